key_debounce_multi: RTL and testbench

KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

---
 rtl/key_debounce_multi.sv | 111 +++++++++++
 tb/tb_key_debounce_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchronizer, per-channel stability counter,
// and registered press / release / long-press pulses for N_KEYS independent keys.
module key_debounce_multi #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int                DB_W     = $clog2(DB_CYCLES);
  localparam int                LONG_W   = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYCLES - 1);
  localparam logic [N_KEYS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_KEYS-1:0] key_p0;
  logic [N_KEYS-1:0] key_p1;
  logic [N_KEYS-1:0] pressed_p1;

  logic [DB_W-1:0]   db_cnt       [N_KEYS];
  logic [DB_W-1:0]   db_cnt_nxt   [N_KEYS];
  logic [LONG_W-1:0] long_cnt     [N_KEYS];
  logic [LONG_W-1:0] long_cnt_nxt [N_KEYS];

  logic [N_KEYS-1:0] level_nxt;
  logic [N_KEYS-1:0] press_nxt;
  logic [N_KEYS-1:0] release_nxt;
  logic [N_KEYS-1:0] long_nxt;

  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] cnt);
    return cnt + DB_W'(1);
  endfunction

  // Holding at LONG_MAX keeps the long-press pulse from repeating during one press.
  function automatic logic [LONG_W-1:0] long_sat_inc(input logic [LONG_W-1:0] cnt);
    return (cnt == LONG_MAX) ? cnt : cnt + LONG_W'(1);
  endfunction

  // ---- stage p0/p1: synchronizer, released level loaded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      key_p0 <= IDLE_RAW;
      key_p1 <= IDLE_RAW;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  assign pressed_p1 = (ACTIVE_LOW != 0) ? ~key_p1 : key_p1;

  // ---- stage p2: debounce, edge and long-press decision
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_nxt[i]   = '0;
      long_cnt_nxt[i] = '0;
      level_nxt[i]    = key_level[i];
      press_nxt[i]    = 1'b0;
      release_nxt[i]  = 1'b0;
      long_nxt[i]     = 1'b0;

      if (pressed_p1[i] != key_level[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          level_nxt[i]   = ~key_level[i];
          press_nxt[i]   = ~key_level[i];
          release_nxt[i] = key_level[i];
        end else begin
          db_cnt_nxt[i] = db_inc(db_cnt[i]);
        end
      end

      // A release toggle clears the long counter and wins over a coincident long pulse.
      if (key_level[i] && !release_nxt[i]) begin
        long_cnt_nxt[i] = long_sat_inc(long_cnt[i]);
        long_nxt[i]     = (long_cnt[i] == LONG_PRE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i]   <= '0;
        long_cnt[i] <= '0;
      end
    end else begin
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i]   <= db_cnt_nxt[i];
        long_cnt[i] <= long_cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: an active-low and an active-high instance,
// directed key sequences, expected pulses queued with their cycle numbers.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int LG = 40;

  typedef struct {
    int inst;
    int kind;
    int ch;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_a = '1;
  logic [NK-1:0] key_b = '0;
  logic [NK-1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [NK-1:0] lvl_b, prs_b, rel_b, lng_b;

  int  cyc = 0;
  int  checks = 0;
  int  fails = 0;
  ev_t exp_q[$];

  key_debounce_multi #(.N_KEYS(NK), .DB_CYCLES(DB), .LONG_CYCLES(LG), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .key(key_a), .key_level(lvl_a),
    .key_press(prs_a), .key_release(rel_a), .key_long(lng_a)
  );

  key_debounce_multi #(.N_KEYS(NK), .DB_CYCLES(DB), .LONG_CYCLES(LG), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .key_level(lvl_b),
    .key_press(prs_b), .key_release(rel_b), .key_long(lng_b)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int inst, input int kind, input int ch, input int at);
    ev_t e;
    e.inst = inst; e.kind = kind; e.ch = ch; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse seen must be the next queued event, in inst/kind/channel order.
  always @(negedge clk) begin
    logic [23:0] vec;
    ev_t e;
    vec = {lng_b, rel_b, prs_b, lng_a, rel_a, prs_a};
    for (int in = 0; in < 2; in++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < NK; c++)
          if (vec[in*12 + k*4 + c]) begin
            checks++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL unexpected_pulse: inst %0d kind %0d ch %0d at cycle %0d, required none",
                       in, k, c, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.inst != in || e.kind != k || e.ch != c || e.cyc != cyc) begin
                fails++;
                $display("FAIL pulse: got inst %0d kind %0d ch %0d cycle %0d, required inst %0d kind %0d ch %0d cycle %0d",
                         in, k, c, cyc, e.inst, e.kind, e.ch, e.cyc);
              end
            end
          end
  end

  initial begin
    int e0;
    int e1;

    // reset state
    edges(3);
    check("rst_level_a", lvl_a, '0);
    check("rst_press_a", prs_a, '0);
    check("rst_release_a", rel_a, '0);
    check("rst_long_a", lng_a, '0);
    check("rst_level_b", lvl_b, '0);
    check("rst_press_b", prs_b, '0);
    check("rst_release_b", rel_b, '0);
    check("rst_long_b", lng_b, '0);
    rst = 1'b0;
    edges(20);

    // bounce: low 5, high 3, low 6, high -> nothing
    key_a[0] = 1'b0; edges(5);
    key_a[0] = 1'b1; edges(3);
    key_a[0] = 1'b0; edges(6);
    key_a[0] = 1'b1; edges(20);
    check("bounce_level", lvl_a, '0);

    // clean press on ch0, held 30 clocks
    key_a[0] = 1'b0; e0 = cyc + 1;
    push(0, 0, 0, e0 + 9);
    edges(30);
    check("clean_level_held", lvl_a, 4'b0001);
    key_a[0] = 1'b1; e1 = cyc + 1;
    push(0, 1, 0, e1 + 9);
    edges(30);
    check("clean_level_after", lvl_a, '0);

    // long press on ch2, held 60 clocks
    key_a[2] = 1'b0; e0 = cyc + 1;
    push(0, 0, 2, e0 + 9);
    push(0, 2, 2, e0 + 9 + LG);
    edges(60);
    check("long_level_held", lvl_a, 4'b0100);
    key_a[2] = 1'b1; e1 = cyc + 1;
    push(0, 1, 2, e1 + 9);
    edges(30);

    // simultaneous press on ch1 and ch3
    key_a[1] = 1'b0; key_a[3] = 1'b0; e0 = cyc + 1;
    push(0, 0, 1, e0 + 9);
    push(0, 0, 3, e0 + 9);
    edges(15);
    check("simul_level", lvl_a, 4'b1010);
    key_a[1] = 1'b1; key_a[3] = 1'b1; e1 = cyc + 1;
    push(0, 1, 1, e1 + 9);
    push(0, 1, 3, e1 + 9);
    edges(30);

    // reset three clocks after key_press[0], key still held
    key_a[0] = 1'b0; e0 = cyc + 1;
    push(0, 0, 0, e0 + 9);
    edges(12);
    rst = 1'b1;
    edges(3);
    check("midrst_level", lvl_a, '0);
    check("midrst_press", prs_a, '0);
    check("midrst_release", rel_a, '0);
    check("midrst_long", lng_a, '0);
    rst = 1'b0;
    push(0, 0, 0, e0 + 15 + 9);
    edges(25);
    check("midrst_level_again", lvl_a, 4'b0001);
    key_a[0] = 1'b1; e1 = cyc + 1;
    push(0, 1, 0, e1 + 9);
    edges(30);

    // active-high instance
    key_b[0] = 1'b1; e0 = cyc + 1;
    push(1, 0, 0, e0 + 9);
    edges(12);
    key_b[0] = 1'b0; e1 = cyc + 1;
    push(1, 1, 0, e1 + 9);
    edges(60);
    check("polarity_level_b", lvl_b, '0);
    check("idle_level_a", lvl_a, '0);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
